uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Round-robin scheduler sharing one UART_TX serializer between N_REQ byte producers.
//  Accepts one byte plus parity config per grant and drives the UART_TX load port.
//  Paces frames off UART_TX Busy, with an optional inter-frame gap.
//  Flags a launch that UART_TX never acknowledges with Busy.
// PARAMETERS
//  N_REQ      4  number of requesters (2..8)
//  DATA_W     8  byte width; must match UART_TX P_DATA
//  IFG_CYCLES 1  idle cycles forced between Busy fall and the next grant (0 = none)
//  BUSY_TMO   4  max cycles spent in WAIT_BUSY before timeout (>=2)
// PORTS
//  clk          in   1              system clock; everything on posedge
//  reset        in   1              asynchronous, active-high reset
//  en           in   1              1 = grants allowed; an in-flight frame always completes
//  req_valid    in   N_REQ          per-requester byte available
//  req_data     in   N_REQ*DATA_W   requester i byte in bits [i*DATA_W +: DATA_W]
//  req_par_en   in   N_REQ          per-requester parity enable
//  req_par_typ  in   N_REQ          per-requester parity type (1 odd, 0 even)
//  req_ready    out  N_REQ          one-hot accept; combinational; transfer on valid&ready
//  P_DATA       out  DATA_W         to UART_TX; registered; held from LAUNCH to end of WAIT_DONE
//  DATA_VALID   out  1              to UART_TX; registered; one-cycle pulse per frame
//  PAR_EN       out  1              to UART_TX; registered; held like P_DATA
//  PAR_TYP      out  1              to UART_TX; registered; held like P_DATA
//  Busy         in   1              from UART_TX; high while a frame is on the line
//  active       out  1              1 in any state other than IDLE
//  cur_id       out  $clog2(N_REQ)  requester that owns the current or last frame
//  done         out  1              one-cycle pulse when Busy falls in WAIT_DONE
//  tmo_err      out  1              one-cycle pulse on WAIT_BUSY timeout
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; all outputs 0; rr_ptr=N_REQ-1, so req 0 has priority first.
//  FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
//  IDLE:
//   - Grant when en & |req_valid & !Busy.
//   - Winner w = first valid requester scanning rr_ptr+1 .. rr_ptr, wrapping modulo N_REQ.
//   - req_ready[w]=1 in that cycle; latch data/par_en/par_typ; cur_id<=w; ->LAUNCH.
//   - If Busy=1 in IDLE (UART held externally), no grant.
//  LAUNCH: DATA_VALID=1 for exactly this cycle, with P_DATA/PAR_* valid; tmo_cnt<=0; ->WAIT_BUSY.
//  WAIT_BUSY:
//   - Busy=1 -> WAIT_DONE.
//   - Else tmo_cnt++; when tmo_cnt==BUSY_TMO-1 pulse tmo_err and ->GAP (no done, rr_ptr unchanged).
//  WAIT_DONE: on Busy=0, pulse done, rr_ptr<=cur_id, then ->GAP if IFG_CYCLES>0 else ->IDLE.
//  GAP: gap_cnt counts 0..IFG_CYCLES-1, then ->IDLE; req_ready stays 0.
//  Latency:
//   - Grant at cycle T; DATA_VALID at T+1; Busy expected at T+2.
//   - Busy lasts 10 cycles (PAR_EN=0) or 11 (PAR_EN=1).
//   - Next grant no earlier than Busy-fall cycle + 1 + IFG_CYCLES.
//  req_ready is never asserted outside IDLE; at most one bit set; never set for a non-valid requester.
//  en falling mid-frame: the frame finishes normally; en only gates IDLE grants.
//  Simultaneous: new req_valid rising in the grant cycle of another requester waits for the next round.
//  Fairness: with all N_REQ valid continuously, grants cycle 0,1,..,N_REQ-1,0 with no repeats.
//  Counter widths: tmo_cnt $clog2(BUSY_TMO), gap_cnt $clog2(IFG_CYCLES+1); neither wraps.
//  P_DATA/PAR_EN/PAR_TYP change only on LAUNCH entry; they never change while Busy=1.
//  Reset mid-frame: outputs drop to 0 asynchronously; the scheduler does not resume the frame.
// STRUCTURE
//  Package uart_tx_sched_pkg: state enum (IDLE..GAP, 3-bit); ID_W=$clog2(N_REQ) helper function.
//  Sub-module rr_arbiter #(N_REQ): inputs req, ptr; outputs one-hot gnt and encoded gnt_id.
//   - Purely combinational.
//   - Reused by the FSM for winner selection.
//  Top: FSM, payload latch, tmo_cnt, gap_cnt, rr_ptr register.
// TESTING (bench pairs with a UART_TX model: Busy high T+2 for 10/11 cycles)
//  1 Reset, then req0 valid, data=8'hA5, par_en=1, par_typ=1:
//    req_ready=4'b0001; DATA_VALID at T+1 with P_DATA=A5; done after 11 Busy cycles; cur_id=0.
//  2 All 4 valid continuously, par_en=0, IFG=1:
//    grants in order 0,1,2,3,0; grant spacing exactly 1+1+10+1+1 = 14 cycles.
//  3 Model never raises Busy, BUSY_TMO=4:
//    tmo_err pulses at T+5; done never pulses; FSM returns to IDLE after gap; next grant goes to req 1.
//  4 en=0 asserted mid-WAIT_DONE with req2 pending:
//    current frame done pulses; no req_ready until en=1.
//  5 Reset asserted 3 cycles into Busy:
//    DATA_VALID/P_DATA/active=0 same cycle; after release, req0 wins first.
//  6 Busy forced high while IDLE with req1 valid:
//    req_ready stays 0 until Busy=0, then grant in that cycle.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_sched_pkg
//   Shared types and helpers for the UART_TX round-robin scheduler.
//   - sched_state_t : scheduler FSM encoding (3 bits; IDLE is all-zero so a
//                     reset state decodes as IDLE on the debug port)
//   - cnt_width()   : $clog2 with a floor of 1, so a counter or index for a
//                     range of 1 or 2 values still gets a real bit
// -----------------------------------------------------------------------------
package uart_tx_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } sched_state_t;

  // Width needed to hold the values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick. The search starts one past ptr and
//   wraps modulo N_REQ, so the requester at ptr has the lowest priority.
// Ports
//   req    in  N_REQ  request vector
//   ptr    in  ID_W   last served requester
//   gnt    out N_REQ  one-hot grant (all zero when req is zero)
//   gnt_id out ID_W   encoded grant (0 when req is zero)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id
);

  logic w_found;
  int   w_idx;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = (int'(ptr) + k) % N_REQ;
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        gnt_id     = ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//   Shares one UART_TX serializer between N_REQ byte producers. In IDLE it
//   grants one requester round-robin, latches its byte and parity settings,
//   pulses DATA_VALID for one cycle and then follows UART_TX Busy to pace
//   frames, with an optional forced idle gap after each frame. A launch that
//   never sees Busy rise within BUSY_TMO cycles raises tmo_err.
//
// Requester handshake: req_valid[i] is held by the producer until accepted;
//   req_ready is combinational, one-hot, only ever set in IDLE and only for a
//   valid requester; a byte transfers in the cycle where valid & ready are
//   both 1, and the producer may change req_data[i] afterwards.
//
// Ports
//   clk, reset    clock; asynchronous active-high reset
//   en            allows new grants in IDLE; an in-flight frame always ends
//   req_valid     per-requester byte available
//   req_data      requester i byte at [i*DATA_W +: DATA_W]
//   req_par_en    per-requester parity enable
//   req_par_typ   per-requester parity type (1 odd, 0 even)
//   req_ready     one-hot accept (combinational)
//   P_DATA        byte to UART_TX (registered, held through the frame)
//   DATA_VALID    one-cycle load pulse to UART_TX (registered)
//   PAR_EN        parity enable to UART_TX (registered, held)
//   PAR_TYP       parity type to UART_TX (registered, held)
//   Busy          UART_TX frame in progress
//   active        scheduler is outside IDLE
//   cur_id        owner of the current or last frame
//   done          one-cycle pulse in the cycle Busy is seen low in WAIT_DONE
//   tmo_err       one-cycle pulse when WAIT_BUSY gives up
//   o_dbg_state   current FSM state (sched_state_t encoding)
// -----------------------------------------------------------------------------
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int DATA_W     = 8,
  parameter  int IFG_CYCLES = 1,
  parameter  int BUSY_TMO   = 4,
  localparam int ID_W       = cnt_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_par_en,
  input  logic [N_REQ-1:0]        req_par_typ,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       P_DATA,
  output logic                    DATA_VALID,
  output logic                    PAR_EN,
  output logic                    PAR_TYP,
  input  logic                    Busy,
  output logic                    active,
  output logic [ID_W-1:0]         cur_id,
  output logic                    done,
  output logic                    tmo_err,
  output logic [2:0]              o_dbg_state
);

  localparam int TMO_W = cnt_width(BUSY_TMO);
  localparam int GAP_W = cnt_width(IFG_CYCLES + 1);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  // After a frame (or timeout) either sit out the gap or go straight to IDLE.
  localparam sched_state_t POST_FRAME = (IFG_CYCLES > 0) ? GAP : IDLE;

  sched_state_t      r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_cur_id;
  logic [DATA_W-1:0] r_data;
  logic              r_par_en;
  logic              r_par_typ;
  logic              r_dv;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;

  logic [N_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]   w_gnt_id;
  logic              w_grant;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_par_en;
  logic              w_sel_par_typ;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (r_rr_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  // A held-busy UART (Busy high while we are idle) blocks grants as well.
  assign w_grant   = (r_state == IDLE) && en && (|req_valid) && !Busy;
  assign req_ready = w_grant ? w_gnt : '0;

  // Payload of the winning requester.
  always_comb begin
    w_sel_data    = '0;
    w_sel_par_en  = 1'b0;
    w_sel_par_typ = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_id == ID_W'(i)) begin
        w_sel_data    = req_data[i*DATA_W +: DATA_W];
        w_sel_par_en  = req_par_en[i];
        w_sel_par_typ = req_par_typ[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_rr_ptr  <= ID_W'(N_REQ - 1);
      r_cur_id  <= '0;
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_dv      <= 1'b0;
      r_tmo_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_data    <= w_sel_data;
            r_par_en  <= w_sel_par_en;
            r_par_typ <= w_sel_par_typ;
            r_cur_id  <= w_gnt_id;
            r_dv      <= 1'b1;
            r_state   <= LAUNCH;
          end
        end

        LAUNCH: begin
          r_dv      <= 1'b0;
          r_tmo_cnt <= '0;
          r_state   <= WAIT_BUSY;
        end

        WAIT_BUSY: begin
          if (Busy) begin
            r_state <= WAIT_DONE;
          end else if (r_tmo_cnt == TMO_LAST) begin
            // Give up on this launch; the pointer is left alone so the same
            // requester keeps its turn.
            r_gap_cnt <= '0;
            r_state   <= POST_FRAME;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end

        WAIT_DONE: begin
          if (!Busy) begin
            r_rr_ptr  <= r_cur_id;
            r_gap_cnt <= '0;
            r_state   <= POST_FRAME;
          end
        end

        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign P_DATA      = r_data;
  assign DATA_VALID  = r_dv;
  assign PAR_EN      = r_par_en;
  assign PAR_TYP     = r_par_typ;
  assign cur_id      = r_cur_id;
  assign active      = (r_state != IDLE);
  assign done        = (r_state == WAIT_DONE) && !Busy;
  assign tmo_err     = (r_state == WAIT_BUSY) && !Busy && (r_tmo_cnt == TMO_LAST);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
//   Directed bench for uart_tx_sched with a small UART_TX model (Busy rises
//   the cycle after DATA_VALID and stays high 10 or 11 cycles). Granted
//   payloads are queued and compared when DATA_VALID appears.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;

  localparam int N_REQ      = 4;
  localparam int DATA_W     = 8;
  localparam int IFG_CYCLES = 1;
  localparam int BUSY_TMO   = 4;
  localparam int ID_W       = 2;
  localparam int PW         = DATA_W + 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic                    en          = 1'b0;
  logic [N_REQ-1:0]        req_valid   = '0;
  logic [N_REQ*DATA_W-1:0] req_data    = '0;
  logic [N_REQ-1:0]        req_par_en  = '0;
  logic [N_REQ-1:0]        req_par_typ = '0;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       P_DATA;
  logic                    DATA_VALID;
  logic                    PAR_EN;
  logic                    PAR_TYP;
  logic                    Busy;
  logic                    active;
  logic [ID_W-1:0]         cur_id;
  logic                    done;
  logic                    tmo_err;
  logic [2:0]              dbg_state;

  uart_tx_sched #(
    .N_REQ      (N_REQ),
    .DATA_W     (DATA_W),
    .IFG_CYCLES (IFG_CYCLES),
    .BUSY_TMO   (BUSY_TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_par_en  (req_par_en),
    .req_par_typ (req_par_typ),
    .req_ready   (req_ready),
    .P_DATA      (P_DATA),
    .DATA_VALID  (DATA_VALID),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .Busy        (Busy),
    .active      (active),
    .cur_id      (cur_id),
    .done        (done),
    .tmo_err     (tmo_err),
    .o_dbg_state (dbg_state)
  );

  // ---------------- UART_TX model ----------------
  logic model_en   = 1'b1;
  logic force_busy = 1'b0;
  int   m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt <= 0;
    end else if (DATA_VALID && model_en) begin
      m_cnt <= PAR_EN ? 11 : 10;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign Busy = (m_cnt != 0) || force_busy;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] lat_frame = '0;

  logic [DATA_W-1:0] d_tab  [N_REQ];
  logic              pe_tab [N_REQ];
  logic              pt_tab [N_REQ];
  int g_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each launch pops the payload the bench queued at grant time; while the
  // model holds Busy the payload must not move.
  always @(negedge clk) begin
    if (!reset && DATA_VALID) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_launch", 32'(DATA_VALID), 32'd0);
      end else begin
        chk("sb_frame", 32'({PAR_EN, PAR_TYP, P_DATA}), 32'(exp_q.pop_front()));
      end
      lat_frame <= {PAR_EN, PAR_TYP, P_DATA};
    end else if (!reset && (m_cnt != 0)) begin
      chk("payload_hold", 32'({PAR_EN, PAR_TYP, P_DATA}), 32'(lat_frame));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_reqs();
    for (int i = 0; i < N_REQ; i++) begin
      req_data[i*DATA_W +: DATA_W] = d_tab[i];
      req_par_en[i]                = pe_tab[i];
      req_par_typ[i]               = pt_tab[i];
    end
  endtask

  // Wait up to max cycles for a grant, require it to be requester id, queue
  // its payload and check the launch cycle that follows.
  task automatic wait_grant(input int id, input int max);
    int k = 0;
    #1;
    while (req_ready === '0 && k < max) begin
      tick();
      k++;
    end
    chk("grant_onehot", 32'(req_ready), 32'(1 << id));
    g_cyc = cyc;
    exp_q.push_back({pe_tab[id], pt_tab[id], d_tab[id]});
    tick();
    chk("launch_dv", 32'(DATA_VALID), 32'd1);
    chk("launch_cur_id", 32'(cur_id), 32'(id));
  endtask

  task automatic wait_pulse(input bit sel_tmo, input int max, output int at);
    int k = 0;
    while (((sel_tmo ? tmo_err : done) !== 1'b1) && k < max) begin
      tick();
      k++;
    end
    chk(sel_tmo ? "tmo_seen" : "done_seen", 32'(sel_tmo ? tmo_err : done), 32'd1);
    at = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t0;
    int at;
    int prev;

    for (int i = 0; i < N_REQ; i++) begin
      d_tab[i]  = 8'($urandom_range(1, 255));
      pe_tab[i] = 1'b0;
      pt_tab[i] = 1'($urandom_range(0, 1));
    end

    // Reset values
    repeat (3) tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_dv", 32'(DATA_VALID), 32'd0);
    chk("rst_pdata", 32'(P_DATA), 32'd0);
    chk("rst_par", 32'({PAR_EN, PAR_TYP}), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_cur_id", 32'(cur_id), 32'd0);
    chk("rst_pulses", 32'({done, tmo_err}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    tick();

    // 1: single requester, parity on, odd
    d_tab[0] = 8'hA5; pe_tab[0] = 1'b1; pt_tab[0] = 1'b1;
    load_reqs();
    en        = 1'b1;
    req_valid = 4'b0001;
    wait_grant(0, 5);
    t0 = g_cyc;
    req_valid = '0;
    chk("t1_pdata", 32'(P_DATA), 32'hA5);
    chk("t1_active", 32'(active), 32'd1);
    wait_pulse(1'b0, 40, at);
    chk("t1_done_latency", 32'(at - t0), 32'd13);
    tick();
    chk("t1_done_single", 32'(done), 32'd0);

    // 2: all requesters valid, no parity, fairness and spacing
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < N_REQ; i++) pe_tab[i] = 1'b0;
    load_reqs();
    req_valid = 4'b1111;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_grant(i % N_REQ, 20);
      if (i > 0) chk("t2_spacing", 32'(g_cyc - prev), 32'd14);
      prev = g_cyc;
    end
    req_valid = '0;
    wait_pulse(1'b0, 40, at);
    chk("t2_done_latency", 32'(at - prev), 32'd12);

    // 3: UART never answers; timeout keeps the same requester's turn
    pe_tab[1] = 1'b1;
    load_reqs();
    model_en  = 1'b0;
    req_valid = 4'b0110;
    wait_grant(1, 10);
    t0 = g_cyc;
    wait_pulse(1'b1, 20, at);
    chk("t3_tmo_latency", 32'(at - t0), 32'd5);
    chk("t3_no_done", 32'(done), 32'd0);
    tick();
    chk("t3_tmo_single", 32'({tmo_err, done}), 32'd0);
    wait_grant(1, 10);
    model_en = 1'b1;
    chk("t3_regrant_gap", 32'(g_cyc - at), 32'd2);

    // 4: en dropped mid-frame with req2 pending
    req_valid = 4'b0100;
    repeat (4) tick();
    en = 1'b0;
    wait_pulse(1'b0, 20, at);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4_no_ready_en0", 32'(req_ready), 32'd0);
    end
    chk("t4_idle", 32'(active), 32'd0);
    en = 1'b1;
    wait_grant(2, 0);
    req_valid = '0;
    wait_pulse(1'b0, 20, at);
    repeat (3) tick();

    // 5: reset three cycles into Busy
    req_valid = 4'b0010;
    wait_grant(1, 5);
    repeat (3) tick();
    chk("t5_busy_before", 32'(Busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_dv", 32'(DATA_VALID), 32'd0);
    chk("t5_pdata", 32'(P_DATA), 32'd0);
    chk("t5_active", 32'(active), 32'd0);
    tick();
    reset     = 1'b0;
    req_valid = 4'b0011;
    wait_grant(0, 3);
    req_valid = '0;
    wait_pulse(1'b0, 20, at);
    repeat (3) tick();

    // 6: UART held busy while idle
    force_busy = 1'b1;
    req_valid  = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_ready_busy", 32'(req_ready), 32'd0);
    end
    force_busy = 1'b0;
    wait_grant(1, 0);
    req_valid = '0;
    wait_pulse(1'b0, 20, at);
    repeat (3) tick();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
